// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the framebuffer scanout arbiter:
//   - DATA_W        : default pixel word width (RGB565)
//   - fb_w / fb_h   : framebuffer dimensions after the display downscale
//   - fb_depth      : pixels per bank
//   - fb_addr_w     : BRAM address width; one extra MSB selects the bank
//   - swap_state_t  : states of the double-buffer swap machine
// -----------------------------------------------------------------------------
package fb_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_t;

  // Framebuffer width in pixels for a given display width and downscale.
  function automatic int fb_w(input int h_active, input int scale_log2);
    return h_active >> scale_log2;
  endfunction

  // Framebuffer height in lines for a given display height and downscale.
  function automatic int fb_h(input int v_active, input int scale_log2);
    return v_active >> scale_log2;
  endfunction

  // Pixels held in one bank.
  function automatic int fb_depth(input int h_active, input int v_active,
                                  input int scale_log2);
    return fb_w(h_active, scale_log2) * fb_h(v_active, scale_log2);
  endfunction

  // Address width covering one bank plus the bank-select MSB.
  function automatic int fb_addr_w(input int h_active, input int v_active,
                                   input int scale_log2);
    return $clog2(fb_depth(h_active, v_active, scale_log2)) + 1;
  endfunction

endpackage

// File: rtl/fb_swap_fsm.sv
// -----------------------------------------------------------------------------
// fb_swap_fsm
// Double-buffer swap control. A swap request from the drawer is latched and
// only committed on the next new-frame pulse, so the scanout bank never
// changes in the middle of a visible frame.
//
// Ports:
//   clk_pixel_in     : pixel clock
//   rst_in           : synchronous, active-low reset
//   swap_req_in      : pulse, back buffer is complete
//   nf_in            : new-frame pulse from the timing generator
//   front_sel_out    : bank currently scanned out (registered)
//   swap_pending_out : request latched, not yet committed (registered)
//   swap_done_out    : one-cycle pulse on the cycle after commit (registered)
// -----------------------------------------------------------------------------
module fb_swap_fsm
  import fb_pkg::*;
(
  input  logic clk_pixel_in,
  input  logic rst_in,
  input  logic swap_req_in,
  input  logic nf_in,
  output logic front_sel_out,
  output logic swap_pending_out,
  output logic swap_done_out
);

  swap_state_t state_r;
  logic        front_sel_r;
  logic        pending_r;
  logic        done_r;

  // Swap state machine with registered outputs. A request arriving in the same
  // cycle as nf_in only arms the machine; the commit waits for the next frame.
  // Requests seen while already pending are dropped rather than queued.
  always_ff @(posedge clk_pixel_in) begin
    if (!rst_in) begin
      state_r     <= SWAP_IDLE;
      front_sel_r <= 1'b0;
      pending_r   <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        SWAP_IDLE: begin
          done_r <= 1'b0;
          if (swap_req_in) begin
            state_r   <= SWAP_PENDING;
            pending_r <= 1'b1;
          end else begin
            state_r   <= SWAP_IDLE;
            pending_r <= 1'b0;
          end
        end
        SWAP_PENDING: begin
          if (nf_in) begin
            state_r     <= SWAP_IDLE;
            front_sel_r <= ~front_sel_r;
            pending_r   <= 1'b0;
            done_r      <= 1'b1;
          end else begin
            state_r   <= SWAP_PENDING;
            pending_r <= 1'b1;
            done_r    <= 1'b0;
          end
        end
        default: begin
          state_r   <= SWAP_IDLE;
          pending_r <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  assign front_sel_out    = front_sel_r;
  assign swap_pending_out = pending_r;
  assign swap_done_out    = done_r;

endmodule

// File: rtl/fb_scan_arbiter.sv
// -----------------------------------------------------------------------------
// fb_scan_arbiter
// Owns the single-port framebuffer BRAM and shares it between display scanout
// and the drawing engine. Scanout fetches (one per SCALE display pixels) always
// win the port; drawer writes use valid/ready and target the back bank only.
// Bank swaps are requested by the drawer and committed at the frame boundary.
//
// Ports:
//   clk_pixel_in     : pixel clock
//   rst_in           : synchronous, active-low reset
//   hcount_in        : timing generator horizontal count
//   vcount_in        : timing generator vertical count
//   ad_in            : active-draw flag
//   nf_in            : new-frame pulse
//   wr_valid_in      : drawer write request
//   wr_addr_in       : pixel index within the back bank
//   wr_data_in       : pixel value
//   wr_ready_out     : write accepted when high together with wr_valid_in
//   swap_req_in      : pulse, back buffer complete
//   swap_pending_out : swap requested but not yet committed
//   swap_done_out    : one-cycle pulse when the swap commits
//   front_sel_out    : bank currently scanned out
//   mem_en_out       : BRAM enable (registered)
//   mem_we_out       : BRAM write enable (registered)
//   mem_addr_out     : BRAM address, MSB is the bank (registered)
//   mem_din_out      : BRAM write data (registered)
//   mem_dout_in      : BRAM read data, READ_LATENCY cycles after the address
//   pix_valid_out    : active flag aligned with pix_data_out
//   pix_data_out     : scanout pixel, zero when inactive
//
// Latency from hcount/vcount/ad_in to pix_valid_out/pix_data_out is
// READ_LATENCY+2 cycles.
// -----------------------------------------------------------------------------
module fb_scan_arbiter
  import fb_pkg::*;
#(
  parameter  int H_ACTIVE     = 1280,
  parameter  int V_ACTIVE     = 720,
  parameter  int SCALE_LOG2   = 2,
  parameter  int DATA_W       = fb_pkg::DATA_W,
  parameter  int READ_LATENCY = 2,
  localparam int ADDR_W       = fb_addr_w(H_ACTIVE, V_ACTIVE, SCALE_LOG2)
) (
  input  logic              clk_pixel_in,
  input  logic              rst_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              ad_in,
  input  logic              nf_in,
  input  logic              wr_valid_in,
  input  logic [ADDR_W-2:0] wr_addr_in,
  input  logic [DATA_W-1:0] wr_data_in,
  output logic              wr_ready_out,
  input  logic              swap_req_in,
  output logic              swap_pending_out,
  output logic              swap_done_out,
  output logic              front_sel_out,
  output logic              mem_en_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_din_out,
  input  logic [DATA_W-1:0] mem_dout_in,
  output logic              pix_valid_out,
  output logic [DATA_W-1:0] pix_data_out
);

  localparam int FB_W     = fb_w(H_ACTIVE, SCALE_LOG2);
  localparam int FB_DEPTH = fb_depth(H_ACTIVE, V_ACTIVE, SCALE_LOG2);
  localparam int LIN_W    = ADDR_W - 1;
  // One stage for the registered address, READ_LATENCY for the BRAM itself.
  localparam int PIPE_D   = READ_LATENCY + 1;

  logic              front_sel_s;
  logic              swap_pending_s;
  logic              scan_slot_s;
  logic [LIN_W-1:0]  scan_lin_s;
  logic              wr_ready_s;
  logic              wr_fire_s;
  logic              wr_in_range_s;

  logic              mem_en_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_din_r;

  logic [PIPE_D-1:0] fetch_vld_r;
  logic [PIPE_D-1:0] ad_dly_r;
  logic [DATA_W-1:0] hold_r;
  logic [DATA_W-1:0] pix_word_s;
  logic              pix_valid_r;
  logic [DATA_W-1:0] pix_data_r;

  fb_swap_fsm u_swap_fsm (
    .clk_pixel_in     (clk_pixel_in),
    .rst_in           (rst_in),
    .swap_req_in      (swap_req_in),
    .nf_in            (nf_in),
    .front_sel_out    (front_sel_s),
    .swap_pending_out (swap_pending_s),
    .swap_done_out    (swap_done_out)
  );

  // Scan slot decode, linear framebuffer index and write handshake.
  // The row*width product is formed at 32 bits and only then cut down to the
  // bank index width, so out-of-range counts wrap instead of overflowing early.
  always_comb begin
    scan_slot_s   = ad_in && (hcount_in[SCALE_LOG2-1:0] == {SCALE_LOG2{1'b0}});
    scan_lin_s    = LIN_W'((32'(vcount_in) >> SCALE_LOG2) * 32'(FB_W)
                           + (32'(hcount_in) >> SCALE_LOG2));
    // Writes are stalled while a swap is pending so the finished frame stays
    // intact until it is displayed.
    wr_ready_s    = rst_in && !scan_slot_s && !swap_pending_s;
    wr_fire_s     = wr_valid_in && wr_ready_s;
    wr_in_range_s = (32'(wr_addr_in) < 32'(FB_DEPTH));
  end

  // Registered BRAM port: scan fetch first, accepted write second, otherwise
  // idle with address and data held to avoid needless toggling.
  always_ff @(posedge clk_pixel_in) begin
    if (!rst_in) begin
      mem_en_r   <= 1'b0;
      mem_we_r   <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
      mem_din_r  <= {DATA_W{1'b0}};
    end else if (scan_slot_s) begin
      mem_en_r   <= 1'b1;
      mem_we_r   <= 1'b0;
      mem_addr_r <= {front_sel_s, scan_lin_s};
    end else if (wr_fire_s) begin
      // Out-of-range writes complete the handshake but never reach the array.
      mem_en_r   <= 1'b1;
      mem_we_r   <= wr_in_range_s;
      mem_addr_r <= {~front_sel_s, wr_addr_in};
      mem_din_r  <= wr_data_in;
    end else begin
      mem_en_r   <= 1'b0;
      mem_we_r   <= 1'b0;
    end
  end

  // Tag which BRAM returns belong to scan fetches, and carry the active flag
  // down the same pipeline depth. Reset flushes both, discarding any fetch in
  // flight.
  always_ff @(posedge clk_pixel_in) begin
    if (!rst_in) begin
      fetch_vld_r <= {PIPE_D{1'b0}};
      ad_dly_r    <= {PIPE_D{1'b0}};
    end else begin
      fetch_vld_r <= {fetch_vld_r[PIPE_D-2:0], scan_slot_s};
      ad_dly_r    <= {ad_dly_r[PIPE_D-2:0], ad_in};
    end
  end

  // Hold the last fetched word; it is replayed for SCALE display pixels.
  always_ff @(posedge clk_pixel_in) begin
    if (!rst_in) begin
      hold_r <= {DATA_W{1'b0}};
    end else if (fetch_vld_r[PIPE_D-1]) begin
      hold_r <= mem_dout_in;
    end else begin
      hold_r <= hold_r;
    end
  end

  // On the cycle a fetch returns, bypass the hold register so the first pixel
  // of each group is not delayed by an extra cycle.
  always_comb begin
    pix_word_s = hold_r;
    if (fetch_vld_r[PIPE_D-1]) begin
      pix_word_s = mem_dout_in;
    end else begin
      pix_word_s = hold_r;
    end
  end

  // Registered pixel output, blanked to zero outside the active region.
  always_ff @(posedge clk_pixel_in) begin
    if (!rst_in) begin
      pix_valid_r <= 1'b0;
      pix_data_r  <= {DATA_W{1'b0}};
    end else begin
      pix_valid_r <= ad_dly_r[PIPE_D-1];
      pix_data_r  <= ad_dly_r[PIPE_D-1] ? pix_word_s : {DATA_W{1'b0}};
    end
  end

  assign wr_ready_out     = wr_ready_s;
  assign swap_pending_out = swap_pending_s;
  assign front_sel_out    = front_sel_s;
  assign mem_en_out       = mem_en_r;
  assign mem_we_out       = mem_we_r;
  assign mem_addr_out     = mem_addr_r;
  assign mem_din_out      = mem_din_r;
  assign pix_valid_out    = pix_valid_r;
  assign pix_data_out     = pix_data_r;

endmodule

// File: doc/fb_scan_arbiter.md
Name: fb_scan_arbiter

Overview:
- Owns the single-port framebuffer BRAM and shares it between display scanout and the drawing engine.
- Scanout fetches are driven by the video timing generator (hcount/vcount/active/new-frame) and always win.
- Drawing writes use a valid/ready handshake and go only to the back buffer.
- Double-buffer swaps are requested by the drawer and committed only at the new-frame boundary, so scanout never tears.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- V_ACTIVE, 720, active lines
- SCALE_LOG2, 2, log2 of the display-to-framebuffer downscale; 2 gives a 320x180 buffer
- DATA_W, 16, pixel word width (RGB565)
- READ_LATENCY, 2, BRAM read latency in cycles
- Derived: FB_W = H_ACTIVE>>SCALE_LOG2; FB_H = V_ACTIVE>>SCALE_LOG2; FB_DEPTH = FB_W*FB_H; ADDR_W = $clog2(FB_DEPTH)+1 (the MSB selects the bank)

Ports:
- clk_pixel_in  in  1  pixel clock
- rst_in  in  1  synchronous, active-low reset
- hcount_in  in  11  timing hcount
- vcount_in  in  10  timing vcount
- ad_in  in  1  active-draw flag
- nf_in  in  1  new-frame pulse
- wr_valid_in  in  1  drawer write request
- wr_addr_in  in  ADDR_W-1  pixel index within the back buffer
- wr_data_in  in  DATA_W  pixel value
- wr_ready_out  out  1  write accepted this cycle when high together with wr_valid_in
- swap_req_in  in  1  pulse: back buffer complete
- swap_pending_out  out  1  swap requested, not yet committed
- swap_done_out  out  1  one-cycle pulse when the swap commits
- front_sel_out  out  1  bank currently scanned out
- mem_en_out  out  1  BRAM enable
- mem_we_out  out  1  BRAM write enable
- mem_addr_out  out  ADDR_W  BRAM address
- mem_din_out  out  DATA_W  BRAM write data
- mem_dout_in  in  DATA_W  BRAM read data
- pix_valid_out  out  1  aligned active flag
- pix_data_out  out  DATA_W  scanout pixel, 0 when inactive

Behaviour:
- Reset (rst_in==0 at a clock edge) clears these to 0: front_sel_out, swap_pending_out, swap_done_out, pix_valid_out, pix_data_out, mem_en_out, mem_we_out, mem_addr_out, mem_din_out, the fetch-valid shift register and the hold register. wr_ready_out is 0 while rst_in==0.
- Reset mid-swap drops the pending swap. Reset during an in-flight fetch discards the returned data.
- Scan slot (combinational): scan_slot = ad_in && hcount_in[SCALE_LOG2-1:0]==0.
- Scan address: {front_sel, (vcount_in>>SCALE_LOG2)*FB_W + (hcount_in>>SCALE_LOG2)}. Compute the product at full width, then truncate to ADDR_W-1 bits.
- Memory port is registered; each cycle exactly one of the following applies:
  - scan_slot: en=1, we=0, scan address.
  - Write accepted: en=1, we=1, addr={~front_sel, wr_addr_in}, din=wr_data_in.
  - Otherwise: en=0, we=0; addr and din hold their values.
- wr_ready_out = rst_in && !scan_slot && !swap_pending_out (combinational).
- A write with wr_addr_in >= FB_DEPTH is accepted (handshake completes) but we stays 0, so it is dropped.
- Fetch-valid shift register has depth READ_LATENCY+1 (one stage for the address register, READ_LATENCY for the BRAM). On its output, the hold register captures mem_dout_in. The hold value is reused for SCALE horizontal pixels.
- ad_in is delayed by READ_LATENCY+2 to give pix_valid_out. pix_data_out = pix_valid_out ? hold : 0, registered.
- Total latency from hcount/vcount/ad_in to pix_valid_out/pix_data_out is READ_LATENCY+2 cycles; with defaults that is 4. The timing-generator consumer delays hs/vs to match.
- Swap FSM has two states, IDLE and PENDING.
  - IDLE, swap_req_in=1: go to PENDING; swap_pending_out=1.
  - PENDING, nf_in=1: front_sel toggles, swap_done_out pulses 1 cycle, go to IDLE.
  - PENDING, swap_req_in=1: ignored (no queueing).
  - IDLE, swap_req_in and nf_in in the same cycle: enter PENDING; the commit happens on the next nf_in, not this one.
  - IDLE, nf_in with no request: no change.
- The front_sel change takes effect on the scan address in the cycle after commit. nf_in occurs outside the active region, so no visible pixel mixes banks.
- Writes are stalled during PENDING so that a finished frame is not modified before display.

Decomposition:
- Package fb_pkg holds DATA_W, the FB_W/FB_H/FB_DEPTH/ADDR_W derivation functions, and typedef enum logic {SWAP_IDLE, SWAP_PENDING} swap_state_t.
- One sub-module, fb_swap_fsm, contains the swap state machine: swap_req_in, nf_in, front_sel_out, swap_pending_out, swap_done_out.
- Address generation, arbitration and the read pipeline stay in the top.

Test Plan:
- Reset, then rst_in=1 with ad_in=0 and wr_valid_in=1, addr=5, data=16'hABCD -> mem_we_out=1, mem_addr_out={1'b1,5} (back bank) one cycle after the handshake; wr_ready_out=1.
- Preload bank 0 with addr==data; sweep hcount 0..7 at vcount 4, ad_in=1 -> fetches at hcount 0 and 4, to addresses 320 and 321. pix_data_out = 320 for 4 pixels, then 321, starting 4 cycles after hcount=0.
- Write held valid across a scan slot at hcount=8 -> wr_ready_out=0 that cycle; accepted next cycle; no write is lost or duplicated.
- swap_req_in pulse at vcount=100, nf_in at vcount=720 -> swap_pending_out=1 and wr_ready_out=0 from the cycle after the request until commit; front_sel_out 0->1; swap_done_out is a 1-cycle pulse; following writes go to bank 0.
- swap_req_in and nf_in in the same cycle -> no toggle; the toggle happens at the next nf_in.
- rst_in=0 while PENDING with a fetch in flight -> front_sel_out=0, swap_pending_out=0, pix_data_out=0; the stale BRAM return is never presented.
